// File: rtl/sci_frame_ctrl_if.sv
// SCI frame controller bus: UART byte input, checker flags, command
// handshake towards the executor, NAK reporting and statistics.
// slave  = frame controller side, master = surrounding logic / bench side.
interface sci_frame_ctrl_if;
  logic        valid;
  logic [7:0]  rx_data;
  logic        hce;
  logic        pie;
  logic        ite;
  logic        cse;
  logic        ece;
  logic        new_instr;
  logic        cmd_valid;
  logic [7:0]  cmd_type;
  logic        cmd_ready;
  logic        nak;
  logic [2:0]  err_code;
  logic        busy;
  logic [7:0]  ovr_cnt;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;

  modport slave (
    input  valid, rx_data, hce, pie, ite, cse, ece, cmd_ready,
    output new_instr, cmd_valid, cmd_type, nak, err_code, busy, ovr_cnt, ok_cnt, err_cnt
  );

  modport master (
    output valid, rx_data, hce, pie, ite, cse, ece, cmd_ready,
    input  new_instr, cmd_valid, cmd_type, nak, err_code, busy, ovr_cnt, ok_cnt, err_cnt
  );
endinterface

// File: rtl/sci_frame_ctrl.sv
// SCI command frame sequencer: hunts the EB 90 header, counts bytes against a
// per-type length, waits for the checker flags to settle, then dispatches the
// command or issues a NAK. Handles inter-byte timeout and overrun while busy.
// Optional macro SCI_STATS_EN: when defined, ok/err/overrun counters are
// implemented; otherwise those outputs are tied to 0.
module sci_frame_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1200,
  parameter int unsigned CHECK_LAT   = 4
) (
  input logic             clk,
  input logic             rst_n,
  sci_frame_ctrl_if.slave bus
);

  localparam int unsigned TmrMax = (TIMEOUT_CYC > CHECK_LAT) ? TIMEOUT_CYC : CHECK_LAT;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam logic [TmrW-1:0] TmrTimeout = TmrW'(TIMEOUT_CYC);
  localparam logic [TmrW-1:0] TmrCheck   = TmrW'(CHECK_LAT);
  localparam logic [TmrW-1:0] TmrOne     = TmrW'(1);

  typedef enum logic [2:0] {StIdle, StRecv, StCheck, StDispatch, StReject} state_e;

  // Frame length in bytes (header included) for a given instruction type.
  function automatic logic [8:0] type_len(input logic [7:0] t);
    case (t)
      8'h63:   type_len = 9'd53;
      8'h87:   type_len = 9'd25;
      8'h94:   type_len = 9'd9;
      8'h13:   type_len = 9'd13;
      8'h25:   type_len = 9'd9;
      8'hFF:   type_len = 9'd4;
      8'hF0:   type_len = 9'd4;
      8'h76:   type_len = 9'd268;
      default: type_len = 9'd4;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [8:0]      idx_q, idx_d;
  logic [8:0]      len_q, len_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [7:0]      cmd_type_q, cmd_type_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            new_instr_q, new_instr_d;
  logic            nak_q, nak_d;
  logic [2:0]      err_code_q, err_code_d;
  logic            busy_q, busy_d;
  logic            ovr_inc, ok_inc, err_inc;
  logic [8:0]      idx_inc, len_eff;
  logic [2:0]      flag_code;

  // Checker flag priority encoding; 0 means the frame is clean.
  always_comb begin
    if (bus.hce)      flag_code = 3'd1;
    else if (bus.pie) flag_code = 3'd2;
    else if (bus.ite) flag_code = 3'd3;
    else if (bus.ece) flag_code = 3'd4;
    else if (bus.cse) flag_code = 3'd5;
    else              flag_code = 3'd0;
  end

  // Next-state and registered-output computation for the frame FSM.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    tmr_d       = tmr_q;
    cmd_type_d  = cmd_type_q;
    cmd_valid_d = cmd_valid_q;
    new_instr_d = 1'b0;
    nak_d       = 1'b0;
    err_code_d  = err_code_q;
    ovr_inc     = 1'b0;
    ok_inc      = 1'b0;
    err_inc     = 1'b0;
    idx_inc     = idx_q + 9'd1;
    // The type byte itself may terminate a minimum-length frame.
    len_eff     = (idx_q == 9'd3) ? type_len(bus.rx_data) : len_q;

    case (state_q)
      StIdle: begin
        if (bus.valid && bus.rx_data == 8'hEB) begin
          state_d = StRecv;
          idx_d   = 9'd1;
          tmr_d   = TmrTimeout;
        end
      end
      StRecv: begin
        if (bus.valid) begin
          tmr_d = TmrTimeout;
          idx_d = idx_inc;
          if (idx_q == 9'd1 && bus.rx_data != 8'h90) begin
            // Bad second header byte: silent resync.
            state_d = StIdle;
            idx_d   = 9'd0;
          end else begin
            if (idx_q == 9'd3) begin
              cmd_type_d = bus.rx_data;
              len_d      = type_len(bus.rx_data);
            end
            if (idx_inc >= 9'd4 && idx_inc == len_eff) begin
              state_d = StCheck;
              tmr_d   = TmrCheck;
            end
          end
        end else if (tmr_q <= TmrOne) begin
          state_d     = StReject;
          idx_d       = 9'd0;
          nak_d       = 1'b1;
          err_code_d  = 3'd7;
          new_instr_d = 1'b1;
          err_inc     = 1'b1;
        end else begin
          tmr_d = tmr_q - TmrOne;
        end
      end
      StCheck: begin
        ovr_inc = bus.valid;
        if (tmr_q <= TmrOne) begin
          idx_d = 9'd0;
          if (flag_code == 3'd0) begin
            state_d     = StDispatch;
            cmd_valid_d = 1'b1;
          end else begin
            state_d     = StReject;
            nak_d       = 1'b1;
            err_code_d  = flag_code;
            new_instr_d = 1'b1;
            err_inc     = 1'b1;
          end
        end else begin
          tmr_d = tmr_q - TmrOne;
        end
      end
      StDispatch: begin
        ovr_inc = bus.valid;
        if (bus.cmd_ready) begin
          state_d     = StIdle;
          cmd_valid_d = 1'b0;
          new_instr_d = 1'b1;
          ok_inc      = 1'b1;
        end
      end
      StReject: begin
        // nak/err_code/new_instr were raised on entry; this is the exit cycle.
        ovr_inc = bus.valid;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // Frame FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= 9'd0;
      len_q       <= 9'd4;
      tmr_q       <= '0;
      cmd_type_q  <= 8'h00;
      cmd_valid_q <= 1'b0;
      new_instr_q <= 1'b0;
      nak_q       <= 1'b0;
      err_code_q  <= 3'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      tmr_q       <= tmr_d;
      cmd_type_q  <= cmd_type_d;
      cmd_valid_q <= cmd_valid_d;
      new_instr_q <= new_instr_d;
      nak_q       <= nak_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.new_instr = new_instr_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_type  = cmd_type_q;
  assign bus.nak       = nak_q;
  assign bus.err_code  = err_code_q;
  assign bus.busy      = busy_q;

`ifdef SCI_STATS_EN
  logic [7:0]  ovr_cnt_q, ovr_cnt_d;
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating statistics counters.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    if (ovr_inc && ovr_cnt_q != 8'hFF)    ovr_cnt_d = ovr_cnt_q + 8'd1;
    if (ok_inc && ok_cnt_q != 16'hFFFF)   ok_cnt_d  = ok_cnt_q + 16'd1;
    if (err_inc && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt_q <= 8'h00;
      ok_cnt_q  <= 16'h0000;
      err_cnt_q <= 16'h0000;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.ovr_cnt = ovr_cnt_q;
  assign bus.ok_cnt  = ok_cnt_q;
  assign bus.err_cnt = err_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = ^{ovr_inc, ok_inc, err_inc};

  assign bus.ovr_cnt = 8'h00;
  assign bus.ok_cnt  = 16'h0000;
  assign bus.err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sci_frame_ctrl.sv
// Self-checking bench for sci_frame_ctrl: a scoreboard of expected outcomes
// (dispatch type or nak code) is filled as frames are sent and drained by a
// monitor when the DUT dispatches or naks. Timing and counters checked inline.
module tb_sci_frame_ctrl;

  localparam int unsigned To = 1200;
  localparam int unsigned Cl = 4;
`ifdef SCI_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  typedef struct packed {
    logic       is_nak;
    logic [2:0] code;
    logic [7:0] typ;
  } exp_t;

  logic clk;
  logic rst_n;
  sci_frame_ctrl_if bus ();

  sci_frame_ctrl #(
    .TIMEOUT_CYC(To),
    .CHECK_LAT  (Cl)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fails  = 0;
  int   ni_seen  = 0;
  int   exp_ni   = 0;
  int   exp_ok   = 0;
  int   exp_err  = 0;
  int   exp_ovr  = 0;
  exp_t sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] st(input int v);
    return Stats ? 32'(v) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.valid   = 1'b1;
    bus.rx_data = b;
    tick();
    bus.valid   = 1'b0;
  endtask

  function automatic logic [7:0] frame_byte(input int i, input logic [7:0] typ);
    case (i)
      0:       return 8'hEB;
      1:       return 8'h90;
      2:       return 8'h04;
      3:       return typ;
      default: return 8'(i);
    endcase
  endfunction

  task automatic send_frame(input logic [7:0] typ, input int n);
    for (int i = 0; i < n; i++) send_byte(frame_byte(i, typ));
  endtask

  task automatic push_exp(input logic is_nak, input logic [2:0] code, input logic [7:0] typ);
    exp_t e;
    e.is_nak = is_nak;
    e.code   = code;
    e.typ    = typ;
    sb_q.push_back(e);
  endtask

  // Bounded wait for nak (want_nak=1) or cmd_valid; n = cycles waited.
  task automatic wait_out(input bit want_nak, output int n);
    n = 0;
    while (!(want_nak ? bus.nak : bus.cmd_valid) && n < 4000) begin
      tick();
      n++;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_new_instr"}, 32'(bus.new_instr), 0);
    check_val({tag, "_cmd_valid"}, 32'(bus.cmd_valid), 0);
    check_val({tag, "_cmd_type"},  32'(bus.cmd_type), 0);
    check_val({tag, "_nak"},       32'(bus.nak), 0);
    check_val({tag, "_err_code"},  32'(bus.err_code), 0);
    check_val({tag, "_busy"},      32'(bus.busy), 0);
    check_val({tag, "_ovr_cnt"},   32'(bus.ovr_cnt), 0);
    check_val({tag, "_ok_cnt"},    32'(bus.ok_cnt), 0);
    check_val({tag, "_err_cnt"},   32'(bus.err_cnt), 0);
  endtask

  task automatic check_counters(input string tag);
    check_val({tag, "_ok_cnt"},  32'(bus.ok_cnt),  st(exp_ok));
    check_val({tag, "_err_cnt"}, 32'(bus.err_cnt), st(exp_err));
    check_val({tag, "_ovr_cnt"}, 32'(bus.ovr_cnt), st(exp_ovr));
  endtask

  // Scoreboard monitor: drains one expected outcome per dispatch or nak.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.new_instr) ni_seen++;
      if (bus.nak || (bus.cmd_valid && bus.cmd_ready)) begin
        if (sb_q.size() == 0) begin
          check_val("sb_unexpected_out", 32'(sb_q.size()), 1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_val("sb_kind", 32'(bus.nak), 32'(e.is_nak));
          if (bus.nak) check_val("sb_err_code", 32'(bus.err_code), 32'(e.code));
          else         check_val("sb_cmd_type", 32'(bus.cmd_type), 32'(e.typ));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int unstable;
    logic [4:0] flags [5];
    logic [2:0] codes [5];
    // flags packed as {hce, pie, ite, ece, cse}
    flags[0] = 5'b00001; codes[0] = 3'd5;
    flags[1] = 5'b10001; codes[1] = 3'd1;
    flags[2] = 5'b01100; codes[2] = 3'd2;
    flags[3] = 5'b00110; codes[3] = 3'd3;
    flags[4] = 5'b00011; codes[4] = 3'd4;

    rst_n         = 1'b0;
    bus.valid     = 1'b0;
    bus.rx_data   = 8'h00;
    {bus.hce, bus.pie, bus.ite, bus.ece, bus.cse} = 5'b0;
    bus.cmd_ready = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Type 94, 9-byte frame, executor ready.
    bus.cmd_ready = 1'b1;
    push_exp(1'b0, 3'd0, 8'h94);
    send_frame(8'h94, 9);
    check_val("s1_busy_in_check", 32'(bus.busy), 1);
    check_val("s1_no_early_valid", 32'(bus.cmd_valid), 0);
    wait_out(1'b0, n);
    check_val("s1_check_latency", 32'(n), 32'(Cl));
    check_val("s1_cmd_type", 32'(bus.cmd_type), 32'h94);
    tick();
    exp_ok++; exp_ni++;
    check_val("s1_valid_one_cycle", 32'(bus.cmd_valid), 0);
    check_val("s1_new_instr", 32'(bus.new_instr), 1);
    check_val("s1_idle", 32'(bus.busy), 0);
    check_counters("s1");

    // Checker errors and their priority.
    for (int k = 0; k < 5; k++) begin
      {bus.hce, bus.pie, bus.ite, bus.ece, bus.cse} = flags[k];
      push_exp(1'b1, codes[k], 8'h00);
      send_frame(8'h94, 9);
      wait_out(1'b1, n);
      exp_err++; exp_ni++;
      check_val("s2_nak_latency", 32'(n), 32'(Cl));
      check_val("s2_err_code", 32'(bus.err_code), 32'(codes[k]));
      check_val("s2_new_instr", 32'(bus.new_instr), 1);
      check_val("s2_no_cmd_valid", 32'(bus.cmd_valid), 0);
      check_counters("s2");
      tick();
      check_val("s2_nak_one_cycle", 32'(bus.nak), 0);
      check_val("s2_code_held", 32'(bus.err_code), 32'(codes[k]));
      check_val("s2_idle", 32'(bus.busy), 0);
      {bus.hce, bus.pie, bus.ite, bus.ece, bus.cse} = 5'b0;
    end

    // Inter-byte timeout.
    push_exp(1'b1, 3'd7, 8'h00);
    send_frame(8'h63, 4);
    wait_out(1'b1, n);
    exp_err++; exp_ni++;
    check_val("s3_timeout_cycles", 32'(n), 32'(To));
    check_val("s3_err_code", 32'(bus.err_code), 7);
    check_val("s3_new_instr", 32'(bus.new_instr), 1);
    tick();
    check_val("s3_idle", 32'(bus.busy), 0);
    check_counters("s3");

    // Junk byte and bad header: silent resync, then a normal frame.
    send_byte(8'h12);
    check_val("s4_junk_ignored", 32'(bus.busy), 0);
    send_byte(8'hEB);
    send_byte(8'h91);
    tick();
    check_val("s4_resync_idle", 32'(bus.busy), 0);
    check_val("s4_no_nak", 32'(bus.nak), 0);
    check_counters("s4_resync");
    push_exp(1'b0, 3'd0, 8'hFF);
    send_frame(8'hFF, 4);
    wait_out(1'b0, n);
    check_val("s4_check_latency", 32'(n), 32'(Cl));
    tick();
    exp_ok++; exp_ni++;
    check_counters("s4");

    // Back-pressure with overrun bytes, release coincides with a new EB.
    bus.cmd_ready = 1'b0;
    push_exp(1'b0, 3'd0, 8'h25);
    send_frame(8'h25, 9);
    wait_out(1'b0, n);
    check_val("s5_check_latency", 32'(n), 32'(Cl));
    unstable = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10 || i == 20 || i == 30) begin
        bus.valid   = 1'b1;
        bus.rx_data = 8'hEB;
      end
      tick();
      bus.valid = 1'b0;
      if (!bus.cmd_valid || bus.cmd_type != 8'h25) unstable++;
    end
    exp_ovr += 3;
    check_val("s5_stable_cycles", 32'(unstable), 0);
    check_counters("s5_hold");
    bus.cmd_ready = 1'b1;
    bus.valid     = 1'b1;
    bus.rx_data   = 8'hEB;
    tick();
    bus.valid = 1'b0;
    exp_ok++; exp_ni++; exp_ovr++;
    check_val("s5_valid_drop", 32'(bus.cmd_valid), 0);
    check_val("s5_new_instr", 32'(bus.new_instr), 1);
    check_val("s5_exit_byte_not_frame", 32'(bus.busy), 0);
    check_counters("s5");

    // Long type-76 frame: no early CHECK around the 8-bit wrap.
    push_exp(1'b0, 3'd0, 8'h76);
    for (int i = 0; i < 268; i++) begin
      send_byte(frame_byte(i, 8'h76));
      if (i == 255 || i == 256 || i == 266) begin
        repeat (2 * Cl) tick();
        check_val("s6_no_early_check", 32'(bus.cmd_valid), 0);
        check_val("s6_still_busy", 32'(bus.busy), 1);
      end
    end
    wait_out(1'b0, n);
    check_val("s6_check_latency", 32'(n), 32'(Cl));
    check_val("s6_cmd_type", 32'(bus.cmd_type), 32'h76);
    tick();
    exp_ok++; exp_ni++;
    check_counters("s6");

    // Asynchronous reset mid-frame.
    send_frame(8'h76, 14);
    check_val("s7_busy_before", 32'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("s7_async");
    repeat (2) tick();
    check_outputs_zero("s7_held");
    exp_ok = 0; exp_err = 0; exp_ovr = 0;
    rst_n = 1'b1;
    tick();
    push_exp(1'b0, 3'd0, 8'h13);
    send_frame(8'h13, 13);
    wait_out(1'b0, n);
    check_val("s7_check_latency", 32'(n), 32'(Cl));
    tick();
    exp_ok++; exp_ni++;
    check_counters("s7");

    repeat (3) tick();
    check_val("sb_drained", 32'(sb_q.size()), 0);
    check_val("new_instr_pulses", 32'(ni_seen), 32'(exp_ni));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
